// File: rtl/div_8b.sv
// div_8b: sequential 8-bit unsigned restoring divider, one quotient bit per clock.
// Latency: 8 cycles from the accepting start edge to the done pulse.
//   With DIV8B_DIVZERO_EN, a zero divisor completes in 1 cycle.
// Backpressure: none; start is only sampled in IDLE/DONE and ignored while busy.
//
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   start, a, b     - request strobe, dividend, divisor (captured on accepted start)
//   quot, rem       - results, valid from done and held until the next completion
//   busy, done      - iterating flag, one-cycle result-valid pulse
//   dbz             - divide-by-zero flag (driven only when DIV8B_DIVZERO_EN is defined)
module div_8b (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] quot,
  output logic [7:0] rem,
  output logic       busy,
  output logic       done,
  output logic       dbz
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state;
  // The dividend register doubles as the quotient accumulator: each
  // iteration shifts a dividend bit out of the top and a quotient bit in at the bottom.
  logic [7:0] dvd;
  logic [7:0] dvs;
  // Stored partial remainder. Between iterations it is always below the
  // divisor, so its 9th bit is always 0. Only the low 8 bits are kept; the full
  // 9-bit value exists as pr_sh.
  logic [7:0] pr;
  logic [2:0] cnt;

  logic [8:0] pr_sh;
  logic [8:0] diff;
  logic       qbit;
  logic [7:0] pr_nxt;
  logic       accept;

  assign accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign busy   = (state == S_BUSY);
  assign done   = (state == S_DONE);

  always_comb begin
    pr_sh  = {pr, dvd[7]};
    diff   = pr_sh - {1'b0, dvs};
    // diff[8] set means the trial subtraction went negative: restore.
    qbit   = ~diff[8];
    pr_nxt = qbit ? diff[7:0] : pr_sh[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      dvd   <= 8'd0;
      dvs   <= 8'd0;
      pr    <= 8'd0;
      cnt   <= 3'd0;
      quot  <= 8'd0;
      rem   <= 8'd0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (accept) begin
            dvd   <= a;
            dvs   <= b;
            pr    <= 8'd0;
            cnt   <= 3'd0;
            state <= S_BUSY;
`ifdef DIV8B_DIVZERO_EN
            // Zero divisor: publish the architected result straight away.
            if (b == 8'd0) begin
              state <= S_DONE;
              quot  <= 8'hFF;
              rem   <= a;
            end
`endif
          end else begin
            state <= S_IDLE;
          end
        end
        S_BUSY: begin
          dvd <= {dvd[6:0], qbit};
          pr  <= pr_nxt;
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            state <= S_DONE;
            quot  <= {dvd[6:0], qbit};
            rem   <= pr_nxt;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DIV8B_DIVZERO_EN
  logic dbz_q;

  // The flag is set by a zero-divisor start. That start is also its completion.
  // Any other accepted start clears it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dbz_q <= 1'b0;
    end else if (accept) begin
      dbz_q <= (b == 8'd0);
    end
  end

  assign dbz = dbz_q;
`else
  assign dbz = 1'b0;
`endif

endmodule
